// File: rtl/lsu_access_ctrl_pkg.sv
// Shared codes for the LSU access controller: LEXT ops, access sizes, FSM states,
// the captured-request struct and small decode helpers.
package lsu_access_ctrl_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  localparam logic [2:0] LEXT_8   = 3'd0;
  localparam logic [2:0] LEXT_8U  = 3'd1;
  localparam logic [2:0] LEXT_16  = 3'd2;
  localparam logic [2:0] LEXT_16U = 3'd3;
  localparam logic [2:0] LEXT_32  = 3'd4;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_ACC1 = 2'd1,
    LSU_ST_ACC2 = 2'd2,
    LSU_ST_RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic                  we;
    logic                  uns;
    logic [1:0]            size;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

  // Access spills into the next word.
  function automatic logic lsu_split(input logic [1:0] size, input logic [1:0] off);
    return (size == LSU_SIZE_H && off == 2'd3) || (size == LSU_SIZE_W && off != 2'd0);
  endfunction

  function automatic logic [3:0] lsu_base_be(input logic [1:0] size);
    case (size)
      LSU_SIZE_B: return 4'b0001;
      LSU_SIZE_H: return 4'b0011;
      LSU_SIZE_W: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] lsu_ext_op(input logic [1:0] size, input logic uns);
    case (size)
      LSU_SIZE_B: return uns ? LEXT_8U : LEXT_8;
      LSU_SIZE_H: return uns ? LEXT_16U : LEXT_16;
      default:    return LEXT_32;
    endcase
  endfunction

endpackage

// File: rtl/lext.sv
// Load-extension unit: selects the byte/half at word_sel and sign/zero extends.
module lext
  import lsu_access_ctrl_pkg::*;
(
  input  logic [31:0] din,
  input  logic [1:0]  word_sel,
  input  logic [2:0]  ext_op,
  output logic [31:0] dout
);
  logic [31:0] sh;
  assign sh = din >> {word_sel, 3'b000};

  always_comb begin
    dout = sh;
    case (ext_op)
      LEXT_8:   dout = {{24{sh[7]}}, sh[7:0]};
      LEXT_8U:  dout = {24'b0, sh[7:0]};
      LEXT_16:  dout = {{16{sh[15]}}, sh[15:0]};
      LEXT_16U: dout = {16'b0, sh[15:0]};
      default:  dout = sh;
    endcase
  end
endmodule

// File: rtl/lsu_store_align.sv
// Two-phase byte-enable and write-data alignment for one access; phase hi is the
// spill into the following word.
module lsu_store_align
  import lsu_access_ctrl_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be_lo,
  output logic [3:0]        be_hi,
  output logic [DATA_W-1:0] wdata_lo,
  output logic [DATA_W-1:0] wdata_hi
);
  logic [7:0]          mask;
  logic [2*DATA_W-1:0] wide;

  assign mask     = {4'b0000, lsu_base_be(size)} << off;
  assign wide     = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
  assign be_lo    = mask[3:0];
  assign be_hi    = mask[7:4];
  assign wdata_lo = wide[DATA_W-1:0];
  assign wdata_hi = wide[2*DATA_W-1:DATA_W];
endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller: one access at a time, word-crossing accesses split
// into two bus cycles. LSU_MISALIGN_TRAP_EN turns crossing accesses into errors.
module lsu_access_ctrl
  import lsu_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);
  lsu_state_e        state, state_nxt;
  lsu_req_t          rq;
  logic [DATA_W-1:0] lo_word, lo_nxt, lext_din, lext_dout, rdata_q;
  logic [ADDR_W-1:0] base;
  logic [3:0]        be_lo, be_hi;
  logic [DATA_W-1:0] wd_lo, wd_hi;
  logic [1:0]        off, sel;
  logic              err_q, req_err, split_q, final_ack;

  assign off    = rq.addr[1:0];
  assign base   = {rq.addr[ADDR_W-1:2], 2'b00};
  assign lo_nxt = (state == LSU_ST_ACC1 && bus_ack) ? bus_rdata : lo_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign split_q  = 1'b0;
  assign req_err  = (req_size == 2'b11) || lsu_split(req_size, req_addr[1:0]);
  assign lext_din = lo_nxt;
  assign sel      = off;
`else
  logic [DATA_W-1:0] hi_word, hi_nxt;
  logic [5:0]        hi_sh;
  assign split_q  = lsu_split(rq.size, off);
  assign req_err  = (req_size == 2'b11);
  assign hi_nxt   = (state == LSU_ST_ACC2 && bus_ack) ? bus_rdata : hi_word;
  assign hi_sh    = 6'd32 - {1'b0, off, 3'b000};
  // Same-cycle bypass of the arriving word lets the result register at the final ack.
  assign lext_din = split_q ? ((lo_nxt >> {off, 3'b000}) | (hi_nxt << hi_sh)) : lo_nxt;
  assign sel      = split_q ? 2'b00 : off;
`endif

  assign final_ack = bus_ack && ((state == LSU_ST_ACC1 && !split_q) || state == LSU_ST_ACC2);

  lext u_lext (
    .din      (lext_din),
    .word_sel (sel),
    .ext_op   (lsu_ext_op(rq.size, rq.uns)),
    .dout     (lext_dout)
  );

  lsu_store_align #(.DATA_W(DATA_W)) u_align (
    .size     (rq.size),
    .off      (off),
    .wdata    (rq.wdata),
    .be_lo    (be_lo),
    .be_hi    (be_hi),
    .wdata_lo (wd_lo),
    .wdata_hi (wd_hi)
  );

  // Bus outputs decode straight from state so an async reset drops bus_req at once.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = '0;
    if (state == LSU_ST_ACC1) begin
      bus_req   = 1'b1;
      bus_we    = rq.we;
      bus_addr  = base;
      bus_be    = be_lo;
      bus_wdata = wd_lo;
    end else if (state == LSU_ST_ACC2) begin
      bus_req   = 1'b1;
      bus_we    = rq.we;
      bus_addr  = base + ADDR_W'(4);
      bus_be    = be_hi;
      bus_wdata = wd_hi;
    end
  end

  assign req_ready  = (state == LSU_ST_IDLE);
  assign resp_valid = (state == LSU_ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_ST_IDLE: if (req_valid) state_nxt = req_err ? LSU_ST_RESP : LSU_ST_ACC1;
      LSU_ST_ACC1: if (bus_ack)   state_nxt = split_q ? LSU_ST_ACC2 : LSU_ST_RESP;
`ifndef LSU_MISALIGN_TRAP_EN
      LSU_ST_ACC2: if (bus_ack)   state_nxt = LSU_ST_RESP;
`endif
      default:                    state_nxt = LSU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq      <= '0;
      lo_word <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == LSU_ST_IDLE && req_valid) begin
        rq      <= '{we: req_we, uns: req_unsigned, size: req_size,
                     addr: req_addr, wdata: req_wdata};
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state == LSU_ST_ACC1 && bus_ack) lo_word <= bus_rdata;
      if (final_ack && !rq.we) rdata_q <= lext_dout;
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               hi_word <= '0;
    else if (state == LSU_ST_ACC2 && bus_ack) hi_word <= bus_rdata;
  end
`endif

endmodule
